alu_arbiter: RTL and testbench

// Shares one combinational 32-bit ALU (add/sub/mul/div/mod/mov, 4-bit flags) between two requesters.

---
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-ALU arbiter.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high for the same
// requester bit. Once raised, valid and its payload stay stable until that transfer happens.
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][3:0]     req_op;
    logic [1:0][N-1:0]   req_a;
    logic [1:0][N-1:0]   req_b;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [N-1:0]        rsp_result;
    logic [3:0]          rsp_flags;
    logic                rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: IDLE accepts, EXEC waits for the ALU to settle, RESP returns.
module alu_arbiter #(
    parameter int N        = 32,
    parameter int DIV_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [1:0]   dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_LAST = 4'd5;

    logic [1:0] state;
    logic       prio;
    logic       owner;
    logic       illegal;
    logic [3:0] cnt;

    logic       grant;
    logic       grant_vld;
    logic [3:0] sel_op;
    logic       sel_legal;
    logic       sel_div;

    assign dbg_state = state;

    always_comb begin
        grant_vld = |bus.req_valid;
        // The priority holder wins a tie; otherwise the only valid requester gets it.
        grant     = bus.req_valid[prio] ? prio : ~prio;
        sel_op    = bus.req_op[grant];
        sel_legal = (sel_op <= OP_LAST);
        sel_div   = (sel_op == OP_DIV) || (sel_op == OP_MOD);

        bus.req_ready = 2'b00;
        if (state == S_IDLE && grant_vld) begin
            bus.req_ready[grant] = 1'b1;
        end

        bus.rsp_valid = 2'b00;
        if (state == S_RESP) begin
            bus.rsp_valid[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            prio           <= 1'b0;
            owner          <= 1'b0;
            illegal        <= 1'b0;
            cnt            <= 4'd0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= 4'd0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= 4'd0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        owner   <= grant;
                        illegal <= ~sel_legal;
                        // An illegal opcode leaves the ALU inputs untouched.
                        if (sel_legal) begin
                            alu_a  <= bus.req_a[grant];
                            alu_b  <= bus.req_b[grant];
                            alu_op <= sel_op;
                        end
                        cnt   <= (sel_legal && sel_div) ? 4'(DIV_WAIT) : 4'd0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (illegal) begin
                            bus.rsp_result <= '0;
                            bus.rsp_flags  <= 4'd0;
                            bus.rsp_err    <= 1'b1;
                        end else begin
                            bus.rsp_result <= alu_result;
                            bus.rsp_flags  <= alu_flags;
                            bus.rsp_err    <= 1'b0;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        prio  <= ~owner;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: models the external ALU and scores responses against
// hand-computed expectations packed as {err, flags, result}.
module tb_alu_arbiter;
    localparam int N        = 32;
    localparam int DIV_WAIT = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_errors;
    int cyc;

    logic [N+4:0] exp_q[$];

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N), .DIV_WAIT(DIV_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .dbg_state  (dbg_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model: flags = {negative, zero, 0, 0}
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a * alu_b;
            4'd3: alu_result = (alu_b == 0) ? '1 : alu_a / alu_b;
            4'd4: alu_result = (alu_b == 0) ? alu_a : alu_a % alu_b;
            4'd5: alu_result = alu_a;
            default: alu_result = '0;
        endcase
        alu_flags = {alu_result[N-1], alu_result == '0, 2'b00};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Issue one op on requester r and score its response; hold>0 stalls rsp_ready that many cycles.
    task automatic issue(input int r, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N+4:0] exp_rsp,
                         input int lat, input int hold);
        int t0;
        bit got_ready;
        bit got_rsp;
        logic [N+4:0] want;
        logic [1:0] onehot;
        onehot = (r == 0) ? 2'b01 : 2'b10;
        exp_q.push_back(exp_rsp);
        got_ready = 0;
        got_rsp = 0;
        t0 = 0;
        @(negedge clk);
        bus.rsp_ready   = (hold > 0) ? ~onehot : 2'b11;
        bus.req_op[r]   = op;
        bus.req_a[r]    = a;
        bus.req_b[r]    = b;
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready[r]) begin
                got_ready = 1;
                t0 = cyc;
                break;
            end
            @(negedge clk);
        end
        check("req_ready", {62'd0, bus.req_ready}, {62'd0, onehot});
        if (!got_ready) begin
            bus.req_valid[r] = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid != 2'b00) begin
                got_rsp = 1;
                break;
            end
        end
        want = exp_q.pop_front();
        check("rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, onehot});
        check("latency", 64'(cyc - t0), 64'(lat));
        check("rsp_data", {27'd0, bus.rsp_err, bus.rsp_flags, bus.rsp_result}, {27'd0, want});
        if (!got_rsp) return;
        if (hold > 0) begin
            bus.req_valid[1-r] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                #1;
                check("stall_valid", {62'd0, bus.rsp_valid}, {62'd0, onehot});
                check("stall_data", {27'd0, bus.rsp_err, bus.rsp_flags, bus.rsp_result}, {27'd0, want});
                check("stall_req_ready", {62'd0, bus.req_ready}, 64'd0);
            end
            bus.req_valid[1-r] = 1'b0;
            bus.rsp_ready = 2'b11;
        end
        @(posedge clk);
        #1;
        check("rsp_done", {62'd0, bus.rsp_valid}, 64'd0);
        check("rsp_hold", {32'd0, bus.rsp_result}, {32'd0, want[N-1:0]});
    endtask

    task automatic round_robin();
        int n0;
        int n1;
        int nresp;
        logic [1:0] g;
        logic [N+4:0] want;
        logic [1:0] owners[$];
        n0 = 0;
        n1 = 0;
        nresp = 0;
        // Priority sits with requester 1 here, so grants run 1,0,1,0,...
        owners = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        exp_q.push_back({5'b0, 32'd6});
        exp_q.push_back({5'b0, 32'd11});
        exp_q.push_back({5'b0, 32'd9});
        exp_q.push_back({5'b0, 32'd12});
        exp_q.push_back({5'b0, 32'd12});
        exp_q.push_back({5'b0, 32'd13});
        exp_q.push_back({5'b0, 32'd15});
        exp_q.push_back({5'b0, 32'd14});
        @(negedge clk);
        bus.rsp_ready = 2'b11;
        bus.req_op[0] = 4'd0;
        bus.req_a[0]  = 32'd11;
        bus.req_b[0]  = 32'd0;
        bus.req_op[1] = 4'd2;
        bus.req_a[1]  = 32'd2;
        bus.req_b[1]  = 32'd3;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 100 && nresp < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (bus.rsp_valid != 2'b00) begin
                want = exp_q.pop_front();
                check("rr_owner", {62'd0, bus.rsp_valid}, {62'd0, owners.pop_front()});
                check("rr_result", {32'd0, bus.rsp_result}, {32'd0, want[N-1:0]});
                nresp++;
            end
            g = bus.req_ready;
            @(posedge clk);
            #1;
            if (g[0]) begin
                n0++;
                if (n0 < 4) bus.req_a[0] = 32'(11 + n0);
                else bus.req_valid[0] = 1'b0;
            end
            if (g[1]) begin
                n1++;
                if (n1 < 4) bus.req_a[1] = 32'(2 + n1);
                else bus.req_valid[1] = 1'b0;
            end
        end
        check("rr_count", 64'(nresp), 64'd8);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
        check("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_data", {27'd0, bus.rsp_err, bus.rsp_flags, bus.rsp_result}, 64'd0);
        check("rst_alu", {28'd0, alu_op, alu_a}, 64'd0);
        check("rst_alu_b", {32'd0, alu_b}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);

        issue(1, 4'd3, 32'd100, 32'd7, {5'b0, 32'd14}, 4, 0);
        issue(0, 4'd0, 32'd5, 32'd7, {5'b0, 32'd12}, 2, 0);
        issue(0, 4'd9, 32'd1, 32'd2, {1'b1, 4'd0, 32'd0}, 2, 0);
        check("illegal_alu_op", {60'd0, alu_op}, 64'd0);
        check("illegal_alu_a", {32'd0, alu_a}, 64'd5);
        check("illegal_alu_b", {32'd0, alu_b}, 64'd7);
        issue(1, 4'd1, 32'd3, 32'd5, {1'b0, 4'b1000, 32'hFFFF_FFFE}, 2, 0);
        issue(1, 4'd5, 32'd0, 32'd99, {1'b0, 4'b0100, 32'd0}, 2, 0);
        issue(1, 4'd4, 32'd100, 32'd7, {5'b0, 32'd2}, 4, 0);
        issue(0, 4'd2, 32'd6, 32'd7, {5'b0, 32'd42}, 2, 5);

        round_robin();

        // Reset while a div is executing: nothing comes back, priority returns to requester 0.
        @(negedge clk);
        bus.req_op[0] = 4'd3;
        bus.req_a[0]  = 32'd50;
        bus.req_b[0]  = 32'd5;
        bus.req_valid = 2'b01;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        check("exec_state", {62'd0, dbg_state}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_idle", {62'd0, dbg_state}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("reset_no_rsp", {62'd0, bus.rsp_valid}, 64'd0);
        end
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        check("reset_prio", {62'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
